alu_dispatcher: RTL
===================

ALU_DISPATCHER -- requirements
Module: alu_dispatcher

Interface
REQ-001: Parameter WIDTH, default 32, operand/result width.
REQ-002: Parameter FIFO_DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-003: Parameter FIX_LAT, default 2, cycles from start_alu pulse to result sampling for fixed-latency ops.
REQ-004: Parameter TIMEOUT_CYCLES, default 1024, wait limit for handshake ops.
REQ-005: Single clock and asynchronous active-low reset; ports clk and rst_n.
REQ-006: clk  in  1  rising-edge clock.
REQ-007: rst_n  in  1  asynchronous active-low reset.
REQ-008: cmd_valid, cmd_ready  in/out  1  command handshake; a command is accepted when both are high.
REQ-009: cmd_op  in  5  ALU opcode; cmd_a, cmd_b  in  WIDTH  operands.
REQ-010: start_alu  out  1  single-cycle issue pulse to the ALU.
REQ-011: op  out  5; A, B  out  WIDTH  issued opcode and operands, held stable from issue until response capture.
REQ-012: busy_alu, valid_alu, error_alu  in  1  ALU status; result  in  WIDTH  ALU result.
REQ-013: rsp_valid, rsp_ready  out/in  1  response handshake.
REQ-014: rsp_data  out  WIDTH; rsp_op  out  5; rsp_error, rsp_timeout  out  1.

Function
REQ-015: Commands enter a FIFO of FIFO_DEPTH; cmd_ready = not full; push and pop in the same cycle on a full FIFO are legal.
REQ-016: FSM states IDLE, ISSUE, WAIT_FIX, WAIT_VLD, RESP.
REQ-017: IDLE -> ISSUE when the FIFO is non-empty and busy_alu is low; the head entry is popped into op/A/B.
REQ-018: ISSUE drives start_alu high for exactly one cycle, then -> WAIT_FIX for fixed ops (0-7, 12, 13, 15, 16-31) or -> WAIT_VLD for handshake ops (8, 9, 10, 11, 14).
REQ-019: WAIT_FIX counts FIX_LAT cycles, then samples result into rsp_data with rsp_error=0 and -> RESP.
REQ-020: WAIT_VLD samples result and error_alu on the first cycle valid_alu is high, then -> RESP.
REQ-021: RESP holds rsp_valid high with stable rsp_* until rsp_ready is high, then -> IDLE; a new issue occurs no earlier than the following cycle.
REQ-022: rsp_op echoes the issued opcode.
REQ-023: valid_alu seen outside WAIT_VLD is ignored.
REQ-024: At most one command is outstanding at the ALU; throughput is one command per (issue + latency + 2) cycles minimum.

Reset
REQ-025: On rst_n low, asynchronously: FSM=IDLE, FIFO empty, start_alu=0, op/A/B=0, rsp_valid=0, rsp_data=0, rsp_op=0, rsp_error=0, rsp_timeout=0; cmd_ready=1 after release.
REQ-026: Reset in any state discards the queued and in-flight commands; no response is produced for them.

Configuration
REQ-027: Macro ALU_DISPATCHER_TIMEOUT_EN: when defined, a counter runs in WAIT_VLD; if valid_alu does not arrive within TIMEOUT_CYCLES cycles, -> RESP with rsp_data=0, rsp_timeout=1, rsp_error=0.
REQ-028: Without ALU_DISPATCHER_TIMEOUT_EN, WAIT_VLD waits indefinitely and rsp_timeout is tied to 0.

Verification
REQ-029: op=0 (AND), a=0xF0F0F0F0, b=0xFF00FF00, ALU model result valid after 2 cycles -> one start_alu pulse, rsp_data=0xF000F000, rsp_error=0.
REQ-030: op=10 (DIV), a=100, b=7, model asserts valid_alu 33 cycles after start with result 14 -> rsp_data=14, rsp_op=10, no second start_alu.
REQ-031: op=10, b=0, model asserts valid_alu with error_alu=1 -> rsp_error=1.
REQ-032: Push 5 commands back-to-back with FIFO_DEPTH=4 while rsp_ready=0 -> cmd_ready low after the 4th accept plus the in-flight pop; all responses returned in order once rsp_ready=1.
REQ-033: With ALU_DISPATCHER_TIMEOUT_EN and TIMEOUT_CYCLES=16, op=9, valid_alu never asserted -> rsp_valid after 16 WAIT_VLD cycles with rsp_timeout=1, rsp_data=0.
REQ-034: rst_n pulsed low during WAIT_VLD -> all outputs at reset values immediately, FIFO empty, no response for the aborted command.

Source files
------------

// File: rtl/alu_dispatcher_if.sv
// Bundle of the command, ALU issue/status and response signals of alu_dispatcher.
// slave = the dispatcher itself, master = whatever drives commands and models the ALU.
interface alu_dispatcher_if #(
    parameter int WIDTH = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [4:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             start_alu;
    logic [4:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy_alu;
    logic             valid_alu;
    logic             error_alu;
    logic [WIDTH-1:0] result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [4:0]       rsp_op;
    logic             rsp_error;
    logic             rsp_timeout;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, busy_alu, valid_alu, error_alu, result, rsp_ready,
        output cmd_ready, start_alu, op, A, B, rsp_valid, rsp_data, rsp_op, rsp_error, rsp_timeout
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, busy_alu, valid_alu, error_alu, result, rsp_ready,
        input  cmd_ready, start_alu, op, A, B, rsp_valid, rsp_data, rsp_op, rsp_error, rsp_timeout
    );
endinterface

// File: rtl/alu_dispatcher.sv
// Queues ALU commands in a FIFO and issues them one at a time, collecting each result.
// Optional macro ALU_DISPATCHER_TIMEOUT_EN bounds the wait on handshake ops.
module alu_dispatcher #(
    parameter int WIDTH          = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int FIX_LAT        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_dispatcher_if.slave   bus
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > FIX_LAT) ? TIMEOUT_CYCLES : FIX_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ISSUE    = 3'd1;
    localparam logic [2:0] WAIT_FIX = 3'd2;
    localparam logic [2:0] WAIT_VLD = 3'd3;
    localparam logic [2:0] RESP     = 3'd4;

    logic [4:0]       r_mem_op [FIFO_DEPTH];
    logic [WIDTH-1:0] r_mem_a  [FIFO_DEPTH];
    logic [WIDTH-1:0] r_mem_b  [FIFO_DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_rsp_data;
    logic [4:0]       r_rsp_op;
    logic             r_rsp_error;
`ifdef ALU_DISPATCHER_TIMEOUT_EN
    logic             r_rsp_timeout;
`endif

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_hs_op;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_push  = bus.cmd_valid && !w_full;
    assign w_pop   = (r_state == IDLE) && !w_empty && !bus.busy_alu;
    assign w_hs_op = r_op inside {5'd8, 5'd9, 5'd10, 5'd11, 5'd14};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_op[r_wr_ptr[PTR_W-1:0]] <= bus.cmd_op;
            r_mem_a[r_wr_ptr[PTR_W-1:0]]  <= bus.cmd_a;
            r_mem_b[r_wr_ptr[PTR_W-1:0]]  <= bus.cmd_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_op          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_rsp_data    <= '0;
            r_rsp_op      <= '0;
            r_rsp_error   <= 1'b0;
`ifdef ALU_DISPATCHER_TIMEOUT_EN
            r_rsp_timeout <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_op    <= r_mem_op[r_rd_ptr[PTR_W-1:0]];
                        r_a     <= r_mem_a[r_rd_ptr[PTR_W-1:0]];
                        r_b     <= r_mem_b[r_rd_ptr[PTR_W-1:0]];
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= w_hs_op ? WAIT_VLD : WAIT_FIX;
                end
                WAIT_FIX: begin
                    if (r_cnt == CNT_W'(FIX_LAT - 1)) begin
                        r_rsp_data    <= bus.result;
                        r_rsp_op      <= r_op;
                        r_rsp_error   <= 1'b0;
`ifdef ALU_DISPATCHER_TIMEOUT_EN
                        r_rsp_timeout <= 1'b0;
`endif
                        r_state       <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT_VLD: begin
                    if (bus.valid_alu) begin
                        r_rsp_data    <= bus.result;
                        r_rsp_op      <= r_op;
                        r_rsp_error   <= bus.error_alu;
`ifdef ALU_DISPATCHER_TIMEOUT_EN
                        r_rsp_timeout <= 1'b0;
`endif
                        r_state       <= RESP;
                    end
`ifdef ALU_DISPATCHER_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_rsp_data    <= '0;
                        r_rsp_op      <= r_op;
                        r_rsp_error   <= 1'b0;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = !w_full;
    assign bus.start_alu = (r_state == ISSUE);
    assign bus.op        = r_op;
    assign bus.A         = r_a;
    assign bus.B         = r_b;
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_op    = r_rsp_op;
    assign bus.rsp_error = r_rsp_error;
`ifdef ALU_DISPATCHER_TIMEOUT_EN
    assign bus.rsp_timeout = r_rsp_timeout;
`else
    assign bus.rsp_timeout = 1'b0;
`endif
endmodule
